// File: rtl/vector_cycle_sequencer.sv
// Vector FIFO plus tester-cycle sequencer for the FF_DB_REG drive channels.
// Each vector is preloaded with LOAD inside a cycle and committed with TRANSFER on its last CLK.
module vector_cycle_sequencer #(
  parameter int NUM_PINS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                STOP,
  input  logic                VEC_WR_EN,
  input  logic [NUM_PINS:0]   VEC_WR_DATA,
  input  logic [7:0]          CYCLE_LENGTH_1,
  input  logic [7:0]          CYCLE_LENGTH_2,
  output logic                LOAD,
  output logic                TRANSFER,
  output logic [NUM_PINS-1:0] D,
  output logic                TEST_CYCLE,
  output logic                EN_FF_LOGIC,
  output logic                VEC_FULL,
  output logic                VEC_EMPTY,
  output logic                OVERFLOW,
  output logic                BUSY,
  output logic                DONE,
  output logic [15:0]         CYCLE_COUNT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, XFER, RUN} state_t;

  // Lengths below 2 cannot hold both a LOAD and a TRANSFER, so they are clamped.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len < 8'd2) ? 8'd2 : len;
  endfunction

  logic [NUM_PINS:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, count_n;
  logic                fifo_empty, fifo_full, push, pop, drop;
  logic [NUM_PINS-1:0] head_data;
  logic                head_tset;

  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n, cur_len, cur_len_n;
  logic                pending, pending_n, pending_tset, pending_tset_n;
  logic                stop_req, stop_n;
  logic                at_boundary, begin_cycle, finish_run, try_preload;

  logic                load_q, load_n, transfer_q, transfer_n;
  logic [NUM_PINS-1:0] d_q, d_n;
  logic                test_cycle_q, test_cycle_n, en_q, en_n;
  logic                busy_q, busy_n, done_q, done_n, overflow_q;
  logic                full_q, empty_q;
  logic [15:0]         cycle_count_q, cycle_count_n;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_C);
  assign head_data   = mem[rd_ptr][NUM_PINS-1:0];
  assign head_tset   = mem[rd_ptr][NUM_PINS];
  assign at_boundary = (cnt == cur_len - 8'd1);

  // A full FIFO still takes a write in the same CLK that frees a slot by popping.
  assign push = VEC_WR_EN && (!fifo_full || pop);
  assign drop = VEC_WR_EN && fifo_full && !pop;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
  end

  // Next-state and next-output logic; every strobe is registered one CLK later.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    cur_len_n      = cur_len;
    pending_n      = pending;
    pending_tset_n = pending_tset;
    stop_n         = stop_req | (STOP & busy_q);
    load_n         = 1'b0;
    transfer_n     = 1'b0;
    d_n            = d_q;
    test_cycle_n   = test_cycle_q;
    en_n           = en_q;
    busy_n         = busy_q;
    done_n         = 1'b0;
    cycle_count_n  = cycle_count_q;
    pop            = 1'b0;
    begin_cycle    = 1'b0;
    finish_run     = 1'b0;
    try_preload    = 1'b0;

    case (state)
      IDLE: begin
        if (START && !fifo_empty) begin
          state_n        = PRIME;
          pop            = 1'b1;
          load_n         = 1'b1;
          d_n            = head_data;
          pending_tset_n = head_tset;
          cycle_count_n  = '0;
          busy_n         = 1'b1;
          stop_n         = 1'b0;
        end
      end
      PRIME: begin
        state_n    = XFER;
        transfer_n = 1'b1;
      end
      XFER: begin
        state_n     = RUN;
        begin_cycle = 1'b1;
      end
      RUN: begin
        if (at_boundary) begin
          if (transfer_q) begin_cycle = 1'b1;
          else            finish_run  = 1'b1;
        end else begin
          cnt_n       = cnt + 8'd1;
          try_preload = (cnt_n < cur_len - 8'd1) && !pending;
          transfer_n  = (cnt_n == cur_len - 8'd1) && pending && !stop_n;
        end
      end
      default: state_n = IDLE;
    endcase

    // Commit the preloaded vector and open a new cycle with its timing set's length.
    if (begin_cycle) begin
      test_cycle_n  = pending_tset;
      en_n          = 1'b1;
      cycle_count_n = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;
      cnt_n         = 8'd0;
      cur_len_n     = eff_len(pending_tset ? CYCLE_LENGTH_2 : CYCLE_LENGTH_1);
      pending_n     = 1'b0;
      try_preload   = 1'b1;
    end

    // Drained or stopped: any preloaded vector is dropped, the FIFO keeps the rest.
    if (finish_run) begin
      state_n   = IDLE;
      en_n      = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b1;
      pending_n = 1'b0;
      stop_n    = 1'b0;
      cnt_n     = 8'd0;
    end

    if (try_preload && !fifo_empty && !stop_n) begin
      pop            = 1'b1;
      load_n         = 1'b1;
      d_n            = head_data;
      pending_n      = 1'b1;
      pending_tset_n = head_tset;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= VEC_WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
      state         <= IDLE;
      cnt           <= 8'd0;
      cur_len       <= 8'd2;
      pending       <= 1'b0;
      pending_tset  <= 1'b0;
      stop_req      <= 1'b0;
      load_q        <= 1'b0;
      transfer_q    <= 1'b0;
      d_q           <= '0;
      test_cycle_q  <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_n;
      full_q        <= (count_n == DEPTH_C);
      empty_q       <= (count_n == '0);
      overflow_q    <= overflow_q | drop;
      state         <= state_n;
      cnt           <= cnt_n;
      cur_len       <= cur_len_n;
      pending       <= pending_n;
      pending_tset  <= pending_tset_n;
      stop_req      <= stop_n;
      load_q        <= load_n;
      transfer_q    <= transfer_n;
      d_q           <= d_n;
      test_cycle_q  <= test_cycle_n;
      en_q          <= en_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      cycle_count_q <= cycle_count_n;
    end
  end

  assign LOAD        = load_q;
  assign TRANSFER    = transfer_q;
  assign D           = d_q;
  assign TEST_CYCLE  = test_cycle_q;
  assign EN_FF_LOGIC = en_q;
  assign VEC_FULL    = full_q;
  assign VEC_EMPTY   = empty_q;
  assign OVERFLOW    = overflow_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign CYCLE_COUNT = cycle_count_q;

endmodule

// File: tb/tb_vector_cycle_sequencer.sv
// Directed bench for vector_cycle_sequencer: each scenario task drives vectors and
// checks strobe timing (indices counted from the PRIME CLK) against hand-derived values.
module tb_vector_cycle_sequencer;

  localparam int NP = 8;

  logic          CLK = 1'b0;
  logic          RST, START, STOP, VEC_WR_EN;
  logic [NP:0]   VEC_WR_DATA;
  logic [7:0]    CYCLE_LENGTH_1, CYCLE_LENGTH_2;
  logic          LOAD, TRANSFER, TEST_CYCLE, EN_FF_LOGIC;
  logic [NP-1:0] D;
  logic          VEC_FULL, VEC_EMPTY, OVERFLOW, BUSY, DONE;
  logic [15:0]   CYCLE_COUNT;

  int n_cmp = 0;
  int n_err = 0;

  int            ld_idx[$];
  logic [NP-1:0] ld_d[$];
  int            tr_idx[$];
  logic          tc_hist[$];
  int            both_high, done_at;
  logic [15:0]   cc_at_done;
  logic          en_at_done, busy_at_done, done_after;

  vector_cycle_sequencer #(.NUM_PINS(NP), .FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .VEC_WR_EN(VEC_WR_EN), .VEC_WR_DATA(VEC_WR_DATA),
    .CYCLE_LENGTH_1(CYCLE_LENGTH_1), .CYCLE_LENGTH_2(CYCLE_LENGTH_2),
    .LOAD(LOAD), .TRANSFER(TRANSFER), .D(D), .TEST_CYCLE(TEST_CYCLE),
    .EN_FF_LOGIC(EN_FF_LOGIC), .VEC_FULL(VEC_FULL), .VEC_EMPTY(VEC_EMPTY),
    .OVERFLOW(OVERFLOW), .BUSY(BUSY), .DONE(DONE), .CYCLE_COUNT(CYCLE_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; START = 1'b0; STOP = 1'b0; VEC_WR_EN = 1'b0; VEC_WR_DATA = '0;
    step; step;
    RST = 1'b0;
  endtask

  task automatic write_vec(input logic tset, input logic [NP-1:0] data);
    VEC_WR_EN = 1'b1; VEC_WR_DATA = {tset, data};
    step;
    VEC_WR_EN = 1'b0;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    step;
    START = 1'b0;
  endtask

  // Records strobes per CLK (index 0 = PRIME) until DONE or the budget runs out.
  task automatic capture(input int max_cycles, input int wr_at, input logic [NP:0] wr_data,
                         input int stop_at, input int start_at);
    ld_idx.delete(); ld_d.delete(); tr_idx.delete(); tc_hist.delete();
    both_high = 0; done_at = -1; cc_at_done = '0; en_at_done = 1'b1; busy_at_done = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (LOAD) begin ld_idx.push_back(i); ld_d.push_back(D); end
      if (TRANSFER) tr_idx.push_back(i);
      if (LOAD && TRANSFER) both_high++;
      tc_hist.push_back(TEST_CYCLE);
      if (DONE) begin
        done_at = i; cc_at_done = CYCLE_COUNT; en_at_done = EN_FF_LOGIC; busy_at_done = BUSY;
        break;
      end
      VEC_WR_EN = (i == wr_at);
      if (i == wr_at) VEC_WR_DATA = wr_data;
      STOP  = (i == stop_at);
      START = (i == start_at);
      step;
      VEC_WR_EN = 1'b0; STOP = 1'b0; START = 1'b0;
    end
    step;
    done_after = DONE;
  endtask

  function automatic logic [32:0] out_vec();
    return {LOAD, TRANSFER, D, TEST_CYCLE, EN_FF_LOGIC, VEC_FULL, VEC_EMPTY,
            OVERFLOW, BUSY, DONE, CYCLE_COUNT};
  endfunction

  localparam logic [32:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 16'h0000};

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++; $display("[TB] FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
    end
    CYCLE_LENGTH_1 = 8'd5; CYCLE_LENGTH_2 = 8'd5;
    for (int k = 0; k < 5; k++) write_vec(1'b0, NP'(k + 1));
    pulse_start; step; step; step;
    RST = 1'b1;
    step;
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++; $display("[TB] FAIL midrun_reset_first_edge: got %h expected %h", out_vec(), RESET_VEC);
    end
    step;
    RST = 1'b0;
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++; $display("[TB] FAIL midrun_reset_second_edge: got %h expected %h", out_vec(), RESET_VEC);
    end
    STOP = 1'b1; step; STOP = 1'b0;
    pulse_start;
    n_cmp++;
    if ({BUSY, LOAD, VEC_EMPTY} !== 3'b001) begin
      n_err++; $display("[TB] FAIL start_on_flushed_fifo: got %b expected 001", {BUSY, LOAD, VEC_EMPTY});
    end
  endtask

  task automatic test_basic_run;
    int            exp_ld[3] = '{0, 2, 7};
    logic [NP-1:0] exp_d[3]  = '{8'hA5, 8'h5A, 8'hFF};
    int            exp_tr[3] = '{1, 6, 11};
    int got;
    do_reset;
    CYCLE_LENGTH_1 = 8'd5; CYCLE_LENGTH_2 = 8'd9;
    write_vec(1'b0, 8'hA5); write_vec(1'b0, 8'h5A); write_vec(1'b0, 8'hFF);
    pulse_start;
    capture(60, -1, '0, -1, 4);
    foreach (exp_ld[k]) begin
      got = (k < ld_idx.size()) ? ld_idx[k] : -1;
      n_cmp++;
      if (got !== exp_ld[k]) begin
        n_err++; $display("[TB] FAIL basic_load_at[%0d]: got %0d expected %0d", k, got, exp_ld[k]);
      end
      n_cmp++;
      if (k >= ld_d.size() || ld_d[k] !== exp_d[k]) begin
        n_err++; $display("[TB] FAIL basic_load_d[%0d]: got %h expected %h", k,
                          (k < ld_d.size()) ? ld_d[k] : 8'hXX, exp_d[k]);
      end
    end
    foreach (exp_tr[k]) begin
      got = (k < tr_idx.size()) ? tr_idx[k] : -1;
      n_cmp++;
      if (got !== exp_tr[k]) begin
        n_err++; $display("[TB] FAIL basic_transfer_at[%0d]: got %0d expected %0d", k, got, exp_tr[k]);
      end
    end
    n_cmp++;
    if (done_at !== 17) begin
      n_err++; $display("[TB] FAIL basic_done_at: got %0d expected 17", done_at);
    end
    n_cmp++;
    if ({cc_at_done, en_at_done, busy_at_done} !== {16'd3, 1'b0, 1'b0}) begin
      n_err++; $display("[TB] FAIL basic_end_state: got count=%0d en=%b busy=%b expected count=3 en=0 busy=0",
                        cc_at_done, en_at_done, busy_at_done);
    end
    n_cmp++;
    if (done_after !== 1'b0 || both_high !== 0) begin
      n_err++; $display("[TB] FAIL basic_done_pulse_overlap: got done_after=%b overlaps=%0d expected 0 0",
                        done_after, both_high);
    end
  endtask

  task automatic test_timing_set;
    int exp_tr[3] = '{1, 5, 12};
    int got;
    do_reset;
    CYCLE_LENGTH_1 = 8'd4; CYCLE_LENGTH_2 = 8'd7;
    write_vec(1'b0, 8'h11); write_vec(1'b1, 8'h22); write_vec(1'b0, 8'h33);
    pulse_start;
    capture(60, -1, '0, -1, -1);
    foreach (exp_tr[k]) begin
      got = (k < tr_idx.size()) ? tr_idx[k] : -1;
      n_cmp++;
      if (got !== exp_tr[k]) begin
        n_err++; $display("[TB] FAIL tset_transfer_at[%0d]: got %0d expected %0d", k, got, exp_tr[k]);
      end
    end
    n_cmp++;
    if (done_at !== 17) begin
      n_err++; $display("[TB] FAIL tset_done_at: got %0d expected 17", done_at);
    end
    n_cmp++;
    if (tc_hist.size() < 14 || {tc_hist[2], tc_hist[6], tc_hist[13]} !== 3'b010) begin
      n_err++; $display("[TB] FAIL tset_test_cycle_sequence: got %0d samples, expected 0,1,0 at 2,6,13",
                        tc_hist.size());
    end
  endtask

  task automatic test_min_length;
    int got;
    do_reset;
    CYCLE_LENGTH_1 = 8'd0; CYCLE_LENGTH_2 = 8'd1;
    write_vec(1'b0, 8'h01); write_vec(1'b0, 8'h02); write_vec(1'b1, 8'h03); write_vec(1'b0, 8'h04);
    pulse_start;
    capture(40, -1, '0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      got = (k < tr_idx.size()) ? tr_idx[k] : -1;
      n_cmp++;
      if (got !== 2 * k + 1) begin
        n_err++; $display("[TB] FAIL minlen_transfer_at[%0d]: got %0d expected %0d", k, got, 2 * k + 1);
      end
      got = (k < ld_idx.size()) ? ld_idx[k] : -1;
      n_cmp++;
      if (got !== 2 * k) begin
        n_err++; $display("[TB] FAIL minlen_load_at[%0d]: got %0d expected %0d", k, got, 2 * k);
      end
    end
    n_cmp++;
    if (done_at !== 10 || cc_at_done !== 16'd4 || both_high !== 0) begin
      n_err++; $display("[TB] FAIL minlen_end: got done=%0d count=%0d overlaps=%0d expected 10 4 0",
                        done_at, cc_at_done, both_high);
    end
  endtask

  task automatic test_late_data;
    do_reset;
    CYCLE_LENGTH_1 = 8'd6; CYCLE_LENGTH_2 = 8'd6;
    write_vec(1'b0, 8'hC3);
    pulse_start;
    // Write is accepted on the edge that starts cnt==2 (index 4); the pop is registered into cnt==3.
    capture(60, 3, {1'b0, 8'h3C}, -1, -1);
    n_cmp++;
    if (ld_idx.size() !== 2 || ld_idx[1] !== 5 || ld_d[1] !== 8'h3C) begin
      n_err++; $display("[TB] FAIL late_load: got %0d loads, second at %0d, expected 2 loads, second at 5 with 3c",
                        ld_idx.size(), (ld_idx.size() > 1) ? ld_idx[1] : -1);
    end
    n_cmp++;
    if (tr_idx.size() !== 2 || tr_idx[1] !== 7) begin
      n_err++; $display("[TB] FAIL late_transfer: got %0d transfers, second at %0d, expected 2, second at 7",
                        tr_idx.size(), (tr_idx.size() > 1) ? tr_idx[1] : -1);
    end
    n_cmp++;
    if (done_at !== 14 || cc_at_done !== 16'd2) begin
      n_err++; $display("[TB] FAIL late_end: got done=%0d count=%0d expected 14 2", done_at, cc_at_done);
    end
  endtask

  task automatic test_full_write_pop;
    do_reset;
    CYCLE_LENGTH_1 = 8'd2; CYCLE_LENGTH_2 = 8'd2;
    for (int k = 0; k < 16; k++) write_vec(1'b0, NP'(k));
    n_cmp++;
    if ({VEC_FULL, OVERFLOW} !== 2'b10) begin
      n_err++; $display("[TB] FAIL full_at_depth: got full,ovf=%b expected 10", {VEC_FULL, OVERFLOW});
    end
    START = 1'b1; VEC_WR_EN = 1'b1; VEC_WR_DATA = {1'b0, 8'hEE};
    step;
    START = 1'b0; VEC_WR_EN = 1'b0;
    n_cmp++;
    if ({VEC_FULL, OVERFLOW, LOAD} !== 3'b101 || D !== 8'h00) begin
      n_err++; $display("[TB] FAIL write_with_pop_when_full: got full,ovf,load=%b d=%h expected 101 d=00",
                        {VEC_FULL, OVERFLOW, LOAD}, D);
    end
    capture(80, -1, '0, -1, -1);
    n_cmp++;
    if (done_at !== 36 || cc_at_done !== 16'd17) begin
      n_err++; $display("[TB] FAIL full_drain_end: got done=%0d count=%0d expected 36 17", done_at, cc_at_done);
    end
    n_cmp++;
    if (ld_d.size() !== 17 || ld_d[16] !== 8'hEE) begin
      n_err++; $display("[TB] FAIL full_last_vector: got %0d loads, last d=%h expected 17 loads, last ee",
                        ld_d.size(), (ld_d.size() > 0) ? ld_d[ld_d.size() - 1] : 8'hXX);
    end
  endtask

  task automatic test_stop_overflow;
    do_reset;
    CYCLE_LENGTH_1 = 8'd3; CYCLE_LENGTH_2 = 8'd3;
    for (int k = 0; k < 17; k++) write_vec(1'b0, NP'(8'h40 + k));
    n_cmp++;
    if ({VEC_FULL, OVERFLOW} !== 2'b11) begin
      n_err++; $display("[TB] FAIL overflow_set: got full,ovf=%b expected 11", {VEC_FULL, OVERFLOW});
    end
    pulse_start;
    capture(60, -1, '0, 5, -1);
    n_cmp++;
    if (done_at !== 8 || cc_at_done !== 16'd2 || tr_idx.size() !== 2) begin
      n_err++; $display("[TB] FAIL stop_end: got done=%0d count=%0d transfers=%0d expected 8 2 2",
                        done_at, cc_at_done, tr_idx.size());
    end
    n_cmp++;
    if ({OVERFLOW, VEC_FULL, VEC_EMPTY} !== 3'b100) begin
      n_err++; $display("[TB] FAIL stop_fifo_flags: got ovf,full,empty=%b expected 100",
                        {OVERFLOW, VEC_FULL, VEC_EMPTY});
    end
    // 0x40..0x42 were popped (the third was the discarded preload); 0x43..0x4F stay queued.
    CYCLE_LENGTH_1 = 8'd2;
    pulse_start;
    capture(80, -1, '0, -1, -1);
    n_cmp++;
    if (cc_at_done !== 16'd13 || done_at !== 28) begin
      n_err++; $display("[TB] FAIL stop_remaining: got count=%0d done=%0d expected 13 28", cc_at_done, done_at);
    end
    n_cmp++;
    if (ld_d.size() !== 13 || ld_d[0] !== 8'h43 || ld_d[12] !== 8'h4F) begin
      n_err++; $display("[TB] FAIL stop_kept_order: got %0d loads first=%h expected 13 loads 43..4f",
                        ld_d.size(), (ld_d.size() > 0) ? ld_d[0] : 8'hXX);
    end
    n_cmp++;
    if ({OVERFLOW, VEC_EMPTY} !== 2'b11) begin
      n_err++; $display("[TB] FAIL overflow_sticky: got ovf,empty=%b expected 11", {OVERFLOW, VEC_EMPTY});
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0; VEC_WR_EN = 1'b0; VEC_WR_DATA = '0;
    CYCLE_LENGTH_1 = 8'd5; CYCLE_LENGTH_2 = 8'd5;
    test_reset;
    test_basic_run;
    test_timing_set;
    test_min_length;
    test_late_data;
    test_full_write_pop;
    test_stop_overflow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
